// File: rtl/atm_session_ctrl_if.sv
// ---------------------------------------------------------------------------
// atm_session_ctrl_if
// Bundles the front-end (card reader / keypad) and back-end (display /
// dispenser) signals of the ATM session controller.
//   master modport : front end / test driver (drives card, op, exit)
//   slave  modport : atm_session_ctrl (drives op_ready and the response)
// Optional build macro: CARD_EXPIRY_CHECK_EN adds exp_date / current_date.
// ---------------------------------------------------------------------------
interface atm_session_ctrl_if #(
  parameter int CARD_W = 11,
  parameter int DATA_W = 10
) ();
  logic              card_valid;
  logic [CARD_W-1:0] card_number;
  logic [DATA_W-1:0] pin;
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op;
  logic [DATA_W-1:0] amount;
  logic [CARD_W-1:0] dest_number;
  logic [DATA_W-1:0] new_pin;
  logic              exit;
  logic              resp_valid;
  logic [2:0]        resp_code;
  logic [DATA_W-1:0] resp_value;
  logic [DATA_W-1:0] resp_aux;
  logic              session_active;
  logic              card_declined;
`ifdef CARD_EXPIRY_CHECK_EN
  logic [10:0]       exp_date;
  logic [10:0]       current_date;
`endif

  modport master (
`ifdef CARD_EXPIRY_CHECK_EN
    output exp_date, current_date,
`endif
    output card_valid, card_number, pin, op_valid, op, amount,
    output dest_number, new_pin, exit,
    input  op_ready, resp_valid, resp_code, resp_value, resp_aux,
    input  session_active, card_declined
  );

  modport slave (
`ifdef CARD_EXPIRY_CHECK_EN
    input  exp_date, current_date,
`endif
    input  card_valid, card_number, pin, op_valid, op, amount,
    input  dest_number, new_pin, exit,
    output op_ready, resp_valid, resp_code, resp_value, resp_aux,
    output session_active, card_declined
  );
endinterface

// File: rtl/atm_session_ctrl.sv
// ---------------------------------------------------------------------------
// atm_session_ctrl
// Multi-account ATM session controller. Holds NUM_ACCOUNTS account slots in
// registers, authenticates a card (LOOKUP + AUTH), then serves one menu
// operation at a time (MENU -> EXEC -> RESP) with one registered response
// strobe per request.
// Ports:
//   clock  : system clock, all state changes on posedge
//   reset  : synchronous, active-high; reinitialises FSM and account table
//   bus    : atm_session_ctrl_if.slave (card/op requests in, response out)
// Optional build macro: CARD_EXPIRY_CHECK_EN enables the card expiry check
//   in AUTH (exp_date latched with the card, compared with current_date).
// ---------------------------------------------------------------------------
module atm_session_ctrl #(
  parameter int NUM_ACCOUNTS = 4,
  parameter int CARD_W       = 11,
  parameter int DATA_W       = 10,
  parameter int CARD_STEP    = 100,
  parameter int MIN_BALANCE  = 500,
  parameter int MAX_TRIES    = 3,
  parameter int UNBAN_COST   = 100
) (
  input  logic              clock,
  input  logic              reset,
  atm_session_ctrl_if.slave bus
);

  localparam int IDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
  localparam int TRY_W = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;

  localparam logic [TRY_W-1:0]  MAX_TRIES_T  = TRY_W'(MAX_TRIES);
  localparam logic [DATA_W-1:0] UNBAN_COST_T = DATA_W'(UNBAN_COST);

  localparam logic [2:0] RC_OK        = 3'd0;
  localparam logic [2:0] RC_NO_ACCT   = 3'd1;
  localparam logic [2:0] RC_WRONG_PIN = 3'd2;
  localparam logic [2:0] RC_BANNED    = 3'd3;
  localparam logic [2:0] RC_INSUFF    = 3'd4;
  localparam logic [2:0] RC_BAD_DEST  = 3'd5;
  localparam logic [2:0] RC_BAD_OP    = 3'd6;
  localparam logic [2:0] RC_EXITED    = 3'd7;

  localparam logic [2:0] OP_BALANCE  = 3'd1;
  localparam logic [2:0] OP_WITHDRAW = 3'd2;
  localparam logic [2:0] OP_TRANSFER = 3'd3;
  localparam logic [2:0] OP_REPORT   = 3'd4;
  localparam logic [2:0] OP_CHPIN    = 3'd5;
  localparam logic [2:0] OP_UNBAN    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_AUTH, S_MENU, S_EXEC, S_RESP
  } state_t;

  // ---------------- account table ----------------
  logic [CARD_W-1:0] card_q  [NUM_ACCOUNTS];
  logic [DATA_W-1:0] pin_q   [NUM_ACCOUNTS];
  logic [DATA_W-1:0] pin_d   [NUM_ACCOUNTS];
  logic [DATA_W-1:0] bal_q   [NUM_ACCOUNTS];
  logic [DATA_W-1:0] bal_d   [NUM_ACCOUNTS];
  logic [DATA_W-1:0] dep_q   [NUM_ACCOUNTS];
  logic [DATA_W-1:0] dep_d   [NUM_ACCOUNTS];
  logic [DATA_W-1:0] wd_q    [NUM_ACCOUNTS];
  logic [DATA_W-1:0] wd_d    [NUM_ACCOUNTS];
  logic [TRY_W-1:0]  tries_q [NUM_ACCOUNTS];
  logic [TRY_W-1:0]  tries_d [NUM_ACCOUNTS];
  logic              ban_q   [NUM_ACCOUNTS];
  logic              ban_d   [NUM_ACCOUNTS];

  // ---------------- session / control state ----------------
  state_t            state_q, state_d;
  logic [CARD_W-1:0] in_card_q, in_card_d;
  logic [DATA_W-1:0] in_pin_q, in_pin_d;
  logic              hit_q, hit_d;
  logic [IDX_W-1:0]  src_q, src_d;
  logic              restricted_q, restricted_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] amount_q, amount_d;
  logic [CARD_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] new_pin_q, new_pin_d;
  logic [2:0]        pend_code_q, pend_code_d;
  logic [DATA_W-1:0] pend_value_q, pend_value_d;
  logic [DATA_W-1:0] pend_aux_q, pend_aux_d;
  logic              resp_valid_q, resp_valid_d;
  logic [2:0]        resp_code_q, resp_code_d;
  logic [DATA_W-1:0] resp_value_q, resp_value_d;
  logic [DATA_W-1:0] resp_aux_q, resp_aux_d;
  logic              declined_q, declined_d;
`ifdef CARD_EXPIRY_CHECK_EN
  logic [10:0]       in_exp_q, in_exp_d;
`endif

  // ---------------- comb helpers ----------------
  logic              lk_hit;
  logic [IDX_W-1:0]  lk_idx;
  logic              dst_hit;
  logic [IDX_W-1:0]  dst_idx;
  logic [DATA_W-1:0] src_bal;
  logic [DATA_W-1:0] dst_bal;
  logic [DATA_W:0]   dst_sum;
  logic [TRY_W-1:0]  tries_inc;

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
  endfunction

  // Parallel compares over all slots. Scanning from the top index down
  // means the last hit assigned is the lowest index, so duplicates resolve
  // to the lowest slot.
  always_comb begin
    lk_hit  = 1'b0;
    lk_idx  = '0;
    dst_hit = 1'b0;
    dst_idx = '0;
    for (int i = NUM_ACCOUNTS - 1; i >= 0; i--) begin
      if (card_q[i] == in_card_q) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (card_q[i] == dest_q) begin
        dst_hit = 1'b1;
        dst_idx = IDX_W'(i);
      end
    end
  end

  // ---------------- next-state / output logic ----------------
  always_comb begin
    state_d      = state_q;
    in_card_d    = in_card_q;
    in_pin_d     = in_pin_q;
    hit_d        = hit_q;
    src_d        = src_q;
    restricted_d = restricted_q;
    op_d         = op_q;
    amount_d     = amount_q;
    dest_d       = dest_q;
    new_pin_d    = new_pin_q;
    pend_code_d  = pend_code_q;
    pend_value_d = pend_value_q;
    pend_aux_d   = pend_aux_q;
`ifdef CARD_EXPIRY_CHECK_EN
    in_exp_d     = in_exp_q;
`endif
    pin_d   = pin_q;
    bal_d   = bal_q;
    dep_d   = dep_q;
    wd_d    = wd_q;
    tries_d = tries_q;
    ban_d   = ban_q;

    resp_valid_d = 1'b0;
    resp_code_d  = RC_OK;
    resp_value_d = '0;
    resp_aux_d   = '0;
    declined_d   = 1'b0;

    src_bal   = bal_q[src_q];
    dst_bal   = bal_q[dst_idx];
    dst_sum   = {1'b0, dst_bal} + {1'b0, amount_q};
    tries_inc = (tries_q[src_q] == MAX_TRIES_T) ? MAX_TRIES_T
                                                : tries_q[src_q] + 1'b1;

    if ((state_q != S_IDLE) && bus.exit) begin
      // Abort overrides everything in flight: no table write, session dropped.
      state_d      = S_IDLE;
      restricted_d = 1'b0;
      resp_valid_d = 1'b1;
      resp_code_d  = RC_EXITED;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.card_valid) begin
            in_card_d = bus.card_number;
            in_pin_d  = bus.pin;
`ifdef CARD_EXPIRY_CHECK_EN
            in_exp_d  = bus.exp_date;
`endif
            state_d   = S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          hit_d   = lk_hit;
          src_d   = lk_idx;
          state_d = S_AUTH;
        end

        S_AUTH: begin
          resp_valid_d = 1'b1;
          restricted_d = 1'b0;
          state_d      = S_IDLE;
          if (!hit_q) begin
            resp_code_d = RC_NO_ACCT;
`ifdef CARD_EXPIRY_CHECK_EN
          end else if (in_exp_q <= bus.current_date) begin
            resp_code_d = RC_BAD_OP;  // EXPIRED shares code 6
`endif
          end else if (pin_q[src_q] != in_pin_q) begin
            resp_code_d    = RC_WRONG_PIN;
            tries_d[src_q] = tries_inc;
            if (tries_inc == MAX_TRIES_T) ban_d[src_q] = 1'b1;
          end else if (ban_q[src_q]) begin
            // Right PIN on a banned card: allow a session that can only unban.
            resp_code_d  = RC_BANNED;
            resp_value_d = src_bal;
            restricted_d = 1'b1;
            state_d      = S_MENU;
          end else begin
            tries_d[src_q] = '0;
            resp_value_d   = src_bal;
            state_d        = S_MENU;
          end
        end

        S_MENU: begin
          if (bus.op_valid) begin
            op_d      = bus.op;
            amount_d  = bus.amount;
            dest_d    = bus.dest_number;
            new_pin_d = bus.new_pin;
            state_d   = S_EXEC;
          end
        end

        S_EXEC: begin
          state_d      = S_RESP;
          pend_code_d  = RC_OK;
          pend_value_d = src_bal;
          pend_aux_d   = '0;
          if ((restricted_q && (op_q != OP_UNBAN)) || (op_q == 3'd0) || (op_q == 3'd7)) begin
            pend_code_d = RC_BAD_OP;
          end else begin
            case (op_q)
              OP_WITHDRAW: begin
                if (amount_q <= src_bal) begin
                  bal_d[src_q] = src_bal - amount_q;
                  wd_d[src_q]  = sat_add(wd_q[src_q], amount_q);
                  pend_value_d = src_bal - amount_q;
                end else begin
                  pend_code_d = RC_INSUFF;
                end
              end
              OP_TRANSFER: begin
                if (!dst_hit || (dest_q == in_card_q) || (dst_idx == src_q)) begin
                  pend_code_d = RC_BAD_DEST;
                end else if (amount_q > src_bal) begin
                  pend_code_d = RC_INSUFF;
                end else if (dst_sum[DATA_W]) begin
                  pend_code_d = RC_BAD_DEST;  // destination would overflow
                end else begin
                  bal_d[src_q]   = src_bal - amount_q;
                  bal_d[dst_idx] = dst_sum[DATA_W-1:0];
                  wd_d[src_q]    = sat_add(wd_q[src_q], amount_q);
                  dep_d[dst_idx] = sat_add(dep_q[dst_idx], amount_q);
                  pend_value_d   = src_bal - amount_q;
                end
              end
              OP_REPORT: begin
                pend_value_d = dep_q[src_q];
                pend_aux_d   = wd_q[src_q];
              end
              OP_CHPIN: begin
                pin_d[src_q] = new_pin_q;
              end
              OP_UNBAN: begin
                if (src_bal >= UNBAN_COST_T) begin
                  bal_d[src_q]   = src_bal - UNBAN_COST_T;
                  ban_d[src_q]   = 1'b0;
                  tries_d[src_q] = '0;
                  restricted_d   = 1'b0;
                  pend_value_d   = src_bal - UNBAN_COST_T;
                end else begin
                  pend_code_d = RC_INSUFF;
                end
              end
              default: begin
                // OP_BALANCE: defaults already report the balance.
              end
            endcase
          end
        end

        S_RESP: begin
          resp_valid_d = 1'b1;
          resp_code_d  = pend_code_q;
          resp_value_d = pend_value_q;
          resp_aux_d   = pend_aux_q;
          state_d      = S_MENU;
        end

        default: state_d = S_IDLE;
      endcase
    end

    declined_d = resp_valid_d && (resp_code_d != RC_OK);
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      in_card_q    <= '0;
      in_pin_q     <= '0;
      hit_q        <= 1'b0;
      src_q        <= '0;
      restricted_q <= 1'b0;
      op_q         <= '0;
      amount_q     <= '0;
      dest_q       <= '0;
      new_pin_q    <= '0;
      pend_code_q  <= '0;
      pend_value_q <= '0;
      pend_aux_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_code_q  <= '0;
      resp_value_q <= '0;
      resp_aux_q   <= '0;
      declined_q   <= 1'b0;
`ifdef CARD_EXPIRY_CHECK_EN
      in_exp_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      in_card_q    <= in_card_d;
      in_pin_q     <= in_pin_d;
      hit_q        <= hit_d;
      src_q        <= src_d;
      restricted_q <= restricted_d;
      op_q         <= op_d;
      amount_q     <= amount_d;
      dest_q       <= dest_d;
      new_pin_q    <= new_pin_d;
      pend_code_q  <= pend_code_d;
      pend_value_q <= pend_value_d;
      pend_aux_q   <= pend_aux_d;
      resp_valid_q <= resp_valid_d;
      resp_code_q  <= resp_code_d;
      resp_value_q <= resp_value_d;
      resp_aux_q   <= resp_aux_d;
      declined_q   <= declined_d;
`ifdef CARD_EXPIRY_CHECK_EN
      in_exp_q     <= in_exp_d;
`endif
    end
  end

  // One register group per account slot.
  for (genvar gi = 0; gi < NUM_ACCOUNTS; gi++) begin : g_slot
    always_ff @(posedge clock) begin
      if (reset) begin
        card_q[gi]  <= CARD_W'((gi + 1) * CARD_STEP);
        pin_q[gi]   <= DATA_W'((gi + 1) * CARD_STEP);
        bal_q[gi]   <= DATA_W'(MIN_BALANCE);
        dep_q[gi]   <= '0;
        wd_q[gi]    <= '0;
        tries_q[gi] <= '0;
        ban_q[gi]   <= 1'b0;
      end else begin
        pin_q[gi]   <= pin_d[gi];
        bal_q[gi]   <= bal_d[gi];
        dep_q[gi]   <= dep_d[gi];
        wd_q[gi]    <= wd_d[gi];
        tries_q[gi] <= tries_d[gi];
        ban_q[gi]   <= ban_d[gi];
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus.op_ready       = (state_q == S_MENU);
  assign bus.session_active = (state_q == S_MENU) || (state_q == S_EXEC) ||
                              (state_q == S_RESP);
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_code      = resp_code_q;
  assign bus.resp_value     = resp_value_q;
  assign bus.resp_aux       = resp_aux_q;
  assign bus.card_declined  = declined_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// ---------------------------------------------------------------------------
// tb_atm_session_ctrl
// Directed self-checking bench for atm_session_ctrl with hand-computed
// expected responses. One line is printed per transaction.
// ---------------------------------------------------------------------------
module tb_atm_session_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  atm_session_ctrl_if #(.CARD_W(11), .DATA_W(10)) bus ();

  atm_session_ctrl #(
    .NUM_ACCOUNTS(4), .CARD_W(11), .DATA_W(10), .CARD_STEP(100),
    .MIN_BALANCE(500), .MAX_TRIES(3), .UNBAN_COST(100)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; all sampling happens 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Present a card; response must be visible exactly two edges later.
  task automatic do_card(input string tag, input int card, input int pin,
                         input int exp_code, input bit chk_val, input int exp_val);
    bus.card_valid  = 1'b1;
    bus.card_number = 11'(card);
    bus.pin         = 10'(pin);
    tick();
    bus.card_valid = 1'b0;
    tick();
    check({tag, "_early"}, 32'(bus.resp_valid), 0);
    tick();
    $display("card %0d pin %0d -> valid %0d code %0d value %0d", card, pin,
             bus.resp_valid, bus.resp_code, bus.resp_value);
    check({tag, "_valid"}, 32'(bus.resp_valid), 1);
    check({tag, "_code"}, 32'(bus.resp_code), 32'(exp_code));
    check({tag, "_decl"}, 32'(bus.card_declined), (exp_code != 0) ? 1 : 0);
    if (chk_val) check({tag, "_value"}, 32'(bus.resp_value), 32'(exp_val));
  endtask

  // Issue one op from MENU; response exactly two edges after acceptance.
  task automatic do_op(input string tag, input int op, input int amount, input int dest,
                       input int npin, input int exp_code, input int exp_val, input int exp_aux);
    check({tag, "_ready"}, 32'(bus.op_ready), 1);
    bus.op_valid    = 1'b1;
    bus.op          = 3'(op);
    bus.amount      = 10'(amount);
    bus.dest_number = 11'(dest);
    bus.new_pin     = 10'(npin);
    tick();
    bus.op_valid = 1'b0;
    tick();
    check({tag, "_early"}, 32'(bus.resp_valid), 0);
    tick();
    $display("op %0d amt %0d dest %0d -> valid %0d code %0d value %0d aux %0d", op, amount,
             dest, bus.resp_valid, bus.resp_code, bus.resp_value, bus.resp_aux);
    check({tag, "_valid"}, 32'(bus.resp_valid), 1);
    check({tag, "_code"}, 32'(bus.resp_code), 32'(exp_code));
    check({tag, "_value"}, 32'(bus.resp_value), 32'(exp_val));
    check({tag, "_aux"}, 32'(bus.resp_aux), 32'(exp_aux));
    check({tag, "_decl"}, 32'(bus.card_declined), (exp_code != 0) ? 1 : 0);
  endtask

  task automatic do_exit(input string tag);
    bus.exit = 1'b1;
    tick();
    bus.exit = 1'b0;
    $display("exit -> valid %0d code %0d active %0d", bus.resp_valid, bus.resp_code,
             bus.session_active);
    check({tag, "_valid"}, 32'(bus.resp_valid), 1);
    check({tag, "_code"}, 32'(bus.resp_code), 7);
    check({tag, "_active"}, 32'(bus.session_active), 0);
  endtask

  initial begin
    bus.card_valid  = 1'b0;
    bus.card_number = '0;
    bus.pin         = '0;
    bus.op_valid    = 1'b0;
    bus.op          = '0;
    bus.amount      = '0;
    bus.dest_number = '0;
    bus.new_pin     = '0;
    bus.exit        = 1'b0;
`ifdef CARD_EXPIRY_CHECK_EN
    bus.exp_date     = 11'd2000;
    bus.current_date = 11'd1000;
`endif

    // Reset state
    do_reset();
    $display("reset -> valid %0d ready %0d active %0d", bus.resp_valid, bus.op_ready,
             bus.session_active);
    check("rst_valid", 32'(bus.resp_valid), 0);
    check("rst_ready", 32'(bus.op_ready), 0);
    check("rst_active", 32'(bus.session_active), 0);
    check("rst_decl", 32'(bus.card_declined), 0);

    // Basic login and balance query
    do_card("login200", 200, 200, 0, 1, 500);
    check("login200_active", 32'(bus.session_active), 1);
    do_op("bal200", 1, 0, 0, 0, 0, 500, 0);
    do_exit("exit1");

    // exit in IDLE is ignored
    bus.exit = 1'b1;
    tick();
    bus.exit = 1'b0;
    check("idle_exit_valid", 32'(bus.resp_valid), 0);

    // Unknown card
    do_card("noacct", 999, 999, 1, 0, 0);
    check("noacct_active", 32'(bus.session_active), 0);

    // Ban after three wrong PINs, restricted session, unban
    do_card("wp1", 100, 7, 2, 0, 0);
    do_card("wp2", 100, 7, 2, 0, 0);
    do_card("wp3", 100, 7, 2, 0, 0);
    do_card("banned", 100, 100, 3, 1, 500);
    check("banned_active", 32'(bus.session_active), 1);
    do_op("restr_bal", 1, 0, 0, 0, 6, 500, 0);
    do_op("unban", 6, 0, 0, 0, 0, 400, 0);
    do_op("wd50", 2, 50, 0, 0, 0, 350, 0);
    do_exit("exit2");
    do_card("relogin100", 100, 100, 0, 1, 350);
    do_exit("exit3");

    // Withdraw boundaries
    do_reset();
    do_card("login300", 300, 300, 0, 1, 500);
    do_op("wd501", 2, 501, 0, 0, 4, 500, 0);
    do_op("wd0", 2, 0, 0, 0, 0, 500, 0);
    do_op("wd500", 2, 500, 0, 0, 0, 0, 0);
    do_exit("exit4");

    // Transfer and report
    do_reset();
    do_card("login100", 100, 100, 0, 1, 500);
    do_op("xfer300", 3, 300, 400, 0, 0, 200, 0);
    do_exit("exit5");
    do_card("login400", 400, 400, 0, 1, 800);
    do_op("rep400", 4, 0, 0, 0, 0, 300, 0);
    do_exit("exit6");
    do_card("login100b", 100, 100, 0, 1, 200);
    do_op("rep100", 4, 0, 0, 0, 0, 0, 300);
    do_exit("exit7");

    // Transfer error paths and bad op codes
    do_card("login200b", 200, 200, 0, 1, 500);
    do_op("xfer_limit", 3, 300, 400, 0, 5, 500, 0);
    do_op("xfer_nodest", 3, 10, 999, 0, 5, 500, 0);
    do_op("xfer_self", 3, 10, 200, 0, 5, 500, 0);
    do_op("xfer_insuff", 3, 501, 100, 0, 4, 500, 0);
    do_op("op0", 0, 0, 0, 0, 6, 500, 0);
    do_op("op7", 7, 0, 0, 0, 6, 500, 0);
    do_op("chpin", 5, 0, 0, 123, 0, 500, 0);
    do_exit("exit8");
    do_card("oldpin200", 200, 200, 2, 0, 0);
    do_card("newpin200", 200, 123, 0, 1, 500);

    // exit in the same cycle an op is offered: exit wins, no debit
    bus.op_valid = 1'b1;
    bus.op       = 3'd2;
    bus.amount   = 10'd100;
    do_exit("exit_vs_op");
    bus.op_valid = 1'b0;
    check("exit_vs_op_ready", 32'(bus.op_ready), 0);
    do_card("after_exit200", 200, 123, 0, 1, 500);
    do_exit("exit9");

    // Reset during EXEC restores the whole table
    do_card("login400b", 400, 400, 0, 1, 800);
    bus.op_valid = 1'b1;
    bus.op       = 3'd2;
    bus.amount   = 10'd100;
    tick();
    bus.op_valid = 1'b0;
    do_reset();
    check("rst_exec_active", 32'(bus.session_active), 0);
    check("rst_exec_valid", 32'(bus.resp_valid), 0);
    do_card("post_rst400", 400, 400, 0, 1, 500);
    do_exit("exit10");
    do_card("post_rst100", 100, 100, 0, 1, 500);
    do_exit("exit11");
    do_card("post_rst200", 200, 200, 0, 1, 500);
    do_exit("exit12");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
Parametrised successor to the single-account-table ATM controller. It holds NUM_ACCOUNTS accounts (card number, PIN, balance, deposit/withdraw totals, wrong-PIN counter, ban flag) in registers. A clocked session FSM authenticates a card and then executes menu operations through a valid/ready handshake, returning one registered response per request. It sits between the card-reader/keypad front end and the display/dispenser back end.

Parameters:
NUM_ACCOUNTS, 4, number of account slots (1..16)
CARD_W, 11, card-number width
DATA_W, 10, PIN, amount and balance width
CARD_STEP, 100, reset card number and PIN of slot i = (i+1)*CARD_STEP
MIN_BALANCE, 500, reset balance of every slot
MAX_TRIES, 3, consecutive wrong PINs that ban an account
UNBAN_COST, 100, fee debited by the unban operation

Ports:
clock  in  1  system clock, all state changes on posedge
reset  in  1  synchronous, active-high
card_valid  in  1  card_number/pin present (sampled only in IDLE)
card_number  in  CARD_W  source card
pin  in  DATA_W  entered PIN
op_valid  in  1  operation request
op_ready  out  1  high only in MENU
op  in  3  1 balance, 2 withdraw, 3 transfer, 4 report, 5 change PIN, 6 unban
amount  in  DATA_W  withdraw/transfer amount
dest_number  in  CARD_W  transfer destination
new_pin  in  DATA_W  PIN for op 5
exit  in  1  abort session
resp_valid  out  1  one-cycle response strobe
resp_code  out  3  0 OK, 1 NO_ACCOUNT, 2 WRONG_PIN, 3 BANNED, 4 INSUFFICIENT, 5 BAD_DEST/LIMIT, 6 EXPIRED/BAD_OP, 7 EXITED
resp_value  out  DATA_W  balance, or deposited total for report
resp_aux  out  DATA_W  withdrawn total for report, else 0
session_active  out  1  high in MENU/EXEC/RESP
card_declined  out  1  one-cycle pulse alongside any non-OK response

Behaviour:
- Reset: all outputs 0, FSM IDLE, table reinitialised (card/PIN = (i+1)*CARD_STEP, balance MIN_BALANCE, totals 0, tries 0, unbanned). Reset mid-session discards the session and any pending operation.
- States: IDLE -> LOOKUP -> AUTH -> MENU -> EXEC -> RESP -> MENU.
- IDLE: card_valid=1 latches card_number/pin -> LOOKUP.
- LOOKUP: one-cycle parallel compare over all slots; on duplicates the lowest index wins.
- AUTH: resp_valid exactly 2 cycles after card_valid is sampled.
  - No match: NO_ACCOUNT -> IDLE.
  - Wrong PIN: tries++ (saturating at MAX_TRIES); banned set when tries reaches MAX_TRIES; WRONG_PIN -> IDLE.
  - Correct PIN, not banned: tries cleared, OK, resp_value = balance -> MENU.
  - Correct PIN, banned: BANNED -> MENU in restricted mode, where only op 6 is accepted.
- MENU: op_ready=1; an op is accepted on op_valid&op_ready; resp_valid follows exactly 2 cycles after acceptance (EXEC, RESP). Only one op is outstanding at a time.
- Op 1: resp_value = balance.
- Op 2: amount <= balance -> debit, withdrawn total += amount, OK; else INSUFFICIENT, no change. amount=0 is OK.
- Op 3 checks, in order:
  - dest missing or dest == source -> BAD_DEST.
  - amount > balance -> INSUFFICIENT.
  - dest balance + amount > 2^DATA_W-1 (computed DATA_W+1 wide) -> BAD_DEST/LIMIT.
  - otherwise debit source, credit dest, source withdrawn += amount, dest deposited += amount, OK.
- Op 4: resp_value = deposited, resp_aux = withdrawn. Totals saturate at 2^DATA_W-1.
- Op 5: PIN := new_pin, OK.
- Op 6: balance >= UNBAN_COST -> debit, clear ban and tries, OK, and restricted mode ends; else INSUFFICIENT.
- Op 0, op 7, or any op other than 6 in restricted mode -> BAD_OP, no state change.
- exit=1 in any non-IDLE state wins over every other event that cycle: no table write, EXITED response that cycle, -> IDLE. exit in IDLE is ignored.
- resp_value shows the post-operation source balance unless stated otherwise.

Optional Feature:
CARD_EXPIRY_CHECK_EN: adds inputs exp_date[11] (sampled with card_valid) and current_date[11].
- With the macro: in AUTH, exp_date <= current_date -> EXPIRED -> IDLE, checked after NO_ACCOUNT and before the PIN compare; the tries counter is not touched.
- Without the macro: both ports are absent and the EXPIRED code is never produced at AUTH.

Test Plan:
- Reset; card 200 with PIN 200 -> 2 cycles later resp OK, value 500, session_active=1; op 1 -> value 500.
- Card 100 with PIN 7, three times -> WRONG_PIN x3. Then PIN 100 -> BANNED; op 1 -> BAD_OP; op 6 -> OK, value 400; op 2 amount 50 -> OK, value 350.
- Session card 300: op 2 amount 501 -> INSUFFICIENT, card_declined pulse, balance 500; op 2 amount 500 -> OK, value 0.
- Session card 100: op 3 to 400 amount 300 -> OK, value 200. Card 400 op 4 -> value 300, aux 0. Card 100 op 4 -> value 0, aux 300.
- Card 400 balance 800: transfer 300 into it -> LIMIT. Dest 999 -> BAD_DEST. dest == source -> BAD_DEST. No balances change.
- exit asserted in the same cycle an op 2 is accepted -> EXITED, balance unchanged, IDLE. Reset during EXEC -> all balances back to 500.
